// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory request channel between CPU fetch and data ports.
// Optional build macro ARB_PERF_CNT_EN adds fetch/data access and stall counters.
//
// state | meaning
// IDLE  | no transaction in flight; data request wins over fetch
// ADDR  | m_valid high with latched request, waiting for m_ready
// RESP  | request accepted, waiting for m_rvalid
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_wait,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_strb,
  input  logic                d_read,
  input  logic                d_write,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_wait,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_write,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_strb,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         cnt_i_acc,
  output logic [31:0]         cnt_d_acc,
  output logic [31:0]         cnt_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic                m_write_q, m_write_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_strb_q, m_strb_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic pend_i, pend_d, advance, resp_fire;

  // Waits depend only on the done flags and CPU inputs, never on m_* inputs.
  assign pend_d    = (d_read | d_write) & ~d_done_q;
  assign pend_i    = i_req & ~i_done_q;
  assign advance   = ~pend_i & ~pend_d;
  assign resp_fire = (state_q == S_RESP) & m_rvalid;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    i_done_d  = i_done_q;
    d_done_d  = d_done_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_strb_d  = m_strb_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    if (advance) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_d) begin
          m_write_d = d_write;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_strb_d  = d_write ? d_strb : '0;
          owner_d   = OWN_D;
          state_d   = S_ADDR;
        end else if (pend_i) begin
          m_write_d = 1'b0;
          m_addr_d  = i_addr;
          m_strb_d  = '0;
          owner_d   = OWN_I;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (m_rvalid) begin
          state_d = S_IDLE;
          if (owner_q == OWN_D) begin
            d_done_d = 1'b1;
            // a store acknowledge carries no data for the CPU
            if (!m_write_q) d_rdata_d = m_rdata;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_I;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_strb_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_strb_q  <= m_strb_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_valid = (state_q == S_ADDR);
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_strb  = m_strb_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_wait  = pend_i;
  assign d_wait  = pend_d;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] cnt_i_acc_q, cnt_i_acc_d;
  logic [31:0] cnt_d_acc_q, cnt_d_acc_d;
  logic [31:0] cnt_stall_q, cnt_stall_d;

  always_comb begin
    cnt_i_acc_d = cnt_i_acc_q;
    cnt_d_acc_d = cnt_d_acc_q;
    cnt_stall_d = cnt_stall_q;
    if (resp_fire && owner_q == OWN_I) cnt_i_acc_d = cnt_i_acc_q + 32'd1;
    if (resp_fire && owner_q == OWN_D) cnt_d_acc_d = cnt_d_acc_q + 32'd1;
    if (pend_i || pend_d)              cnt_stall_d = cnt_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_i_acc_q <= '0;
      cnt_d_acc_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      cnt_i_acc_q <= cnt_i_acc_d;
      cnt_d_acc_q <= cnt_d_acc_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign cnt_i_acc = cnt_i_acc_q;
  assign cnt_d_acc = cnt_d_acc_q;
  assign cnt_stall = cnt_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: CPU driver, bus-bridge model and a transaction-level
// reference (expected bus transaction queue, held read data, per-port done state).
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_wait;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_strb;
  logic          d_read, d_write;
  logic [DW-1:0] d_rdata;
  logic          d_wait;
  logic          m_valid, m_ready, m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_strb;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   cnt_i_acc, cnt_d_acc, cnt_stall;
  int            stall_ref;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_wait(i_wait),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_strb(d_strb),
    .d_read(d_read), .d_write(d_write), .d_rdata(d_rdata), .d_wait(d_wait),
    .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_strb(m_strb), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
`ifdef ARB_PERF_CNT_EN
    , .cnt_i_acc(cnt_i_acc), .cnt_d_acc(cnt_d_acc), .cnt_stall(cnt_stall)
`endif
  );

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } txn_t;

  txn_t          exp_q[$];
  txn_t          cur;
  int            checks = 0;
  int            errors = 0;

  bit            mi_done, md_done, adv_next, hold_resp, cap_vld, rd_fix_en;
  logic [DW-1:0] mi_rdata, md_rdata, rd_fix;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [SW-1:0] cap_strb;
  logic          cap_wr;
  int            br_st, br_dly, rdy_pct, max_dly, n_acc, n_i_resp, n_d_resp;

`ifdef ARB_PERF_CNT_EN
  always @(posedge clk) begin
    if (rst) stall_ref <= 0;
    else if (i_wait || d_wait) stall_ref <= stall_ref + 1;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: compare DUT against the model, then play the bridge for the coming edge.
  task automatic tick();
    logic [DW-1:0] rd;
    @(negedge clk);
    chk("i_wait", {31'b0, i_wait}, {31'b0, i_req && !mi_done});
    chk("d_wait", {31'b0, d_wait}, {31'b0, (d_read || d_write) && !md_done});
    chk("i_rdata", i_rdata, mi_rdata);
    chk("d_rdata", d_rdata, md_rdata);
    adv_next = !(i_req && !mi_done) && !((d_read || d_write) && !md_done);
    if (adv_next) begin
      mi_done = 0;
      md_done = 0;
    end
    m_rvalid = 1'b0;
    if (br_st == 0) begin
      m_ready = 1'b0;
      if (m_valid) begin
        if (!cap_vld) begin
          cap_vld = 1; cap_addr = m_addr; cap_wdata = m_wdata;
          cap_strb = m_strb; cap_wr = m_write;
        end else begin
          chk("hold_addr", m_addr, cap_addr);
          chk("hold_wdata", m_wdata, cap_wdata);
          chk("hold_strb", {28'b0, m_strb}, {28'b0, cap_strb});
          chk("hold_write", {31'b0, m_write}, {31'b0, cap_wr});
        end
        if ($urandom_range(99, 0) < rdy_pct) begin
          m_ready = 1'b1;
          cap_vld = 0;
          n_acc++;
          chk("txn_expected", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          chk("m_write", {31'b0, m_write}, {31'b0, cur.wr});
          chk("m_addr", m_addr, cur.addr);
          chk("m_strb", {28'b0, m_strb}, {28'b0, cur.strb});
          if (cur.wr) chk("m_wdata", m_wdata, cur.wdata);
          br_st = 1;
          br_dly = $urandom_range(max_dly, 0);
        end
      end
    end else begin
      m_ready = 1'b0;
      chk("m_valid_resp", {31'b0, m_valid}, 32'd0);
      if (!hold_resp) begin
        if (br_dly == 0) begin
          rd = rd_fix_en ? rd_fix : $urandom;
          m_rvalid = 1'b1;
          m_rdata = rd;
          br_st = 0;
          if (cur.is_d) begin
            md_done = 1; n_d_resp++;
            if (!cur.wr) md_rdata = rd;
          end else begin
            mi_done = 1; n_i_resp++;
            mi_rdata = rd;
          end
        end else br_dly--;
      end
    end
  endtask

  task automatic start_step(input logic iq, input logic [AW-1:0] ia, input logic [1:0] dop,
                            input logic [AW-1:0] da, input logic [DW-1:0] wd,
                            input logic [SW-1:0] st);
    txn_t t;
    i_req = iq; i_addr = ia; d_read = dop[0]; d_write = dop[1];
    d_addr = da; d_wdata = wd; d_strb = st;
    n_acc = 0;
    if (dop != 2'b00) begin
      t.is_d = 1; t.wr = dop[1]; t.addr = da; t.wdata = wd; t.strb = dop[1] ? st : '0;
      exp_q.push_back(t);
    end
    if (iq) begin
      t.is_d = 0; t.wr = 0; t.addr = ia; t.wdata = '0; t.strb = '0;
      exp_q.push_back(t);
    end
  endtask

  task automatic run_to_adv(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!adv_next && n < budget);
    chk("adv_reached", {31'b0, adv_next}, 32'd1);
    chk("txns_left", exp_q.size(), 32'd0);
  endtask

  // Step ends one cycle after the advance edge so the next request appears a cycle later.
  task automatic do_step(input logic iq, input logic [AW-1:0] ia, input logic [1:0] dop,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st);
    start_step(iq, ia, dop, da, wd, st);
    run_to_adv(300);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 0; d_read = 0; d_write = 0; m_ready = 0; m_rvalid = 0; m_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    br_st = 0; cap_vld = 0; mi_done = 0; md_done = 0; adv_next = 0; hold_resp = 0;
    mi_rdata = '0; md_rdata = '0; n_i_resp = 0; n_d_resp = 0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] saved;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_strb = '0;
    rdy_pct = 100; max_dly = 0; rd_fix_en = 0; rd_fix = '0;
    do_reset();
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_write", {31'b0, m_write}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_strb", {28'b0, m_strb}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    // fetch only, fastest bridge: m_valid one cycle after request, wait low three cycles after
    rd_fix_en = 1; rd_fix = 32'h0050_0093;
    start_step(1'b1, 32'h100, 2'b00, '0, '0, '0);
    tick();
    chk("lat_m_valid", {31'b0, m_valid}, 32'd1);
    chk("lat_m_write", {31'b0, m_write}, 32'd0);
    chk("lat_m_strb", {28'b0, m_strb}, 32'd0);
    tick();
    tick();
    chk("lat_i_wait", {31'b0, i_wait}, 32'd0);
    chk("lat_i_rdata", i_rdata, 32'h0050_0093);
    rd_fix_en = 0;
    tick();
    chk("no_reissue", {31'b0, m_valid}, 32'd0);
    chk("lat_n_acc", n_acc, 32'd1);

    // concurrent load and fetch: data first, exactly two transactions
    do_step(1'b1, 32'h108, 2'b01, 32'h2004, '0, '0);
    chk("ld_if_n_acc", n_acc, 32'd2);

    // store leaves d_rdata unchanged
    saved = md_rdata;
    do_step(1'b1, 32'h10C, 2'b10, 32'h3001, 32'h0000_AB00, 4'b0010);
    chk("st_n_acc", n_acc, 32'd2);
    chk("st_d_rdata", d_rdata, saved);

    // read and write together behaves as a write
    do_step(1'b1, 32'h110, 2'b11, 32'h3008, 32'h1234_5678, 4'b1111);

    // backpressure: request held stable, nothing else issued
    rdy_pct = 0;
    start_step(1'b1, 32'h400, 2'b10, 32'h500, 32'hCAFE_F00D, 4'b1001);
    repeat (6) tick();
    chk("bp_m_valid", {31'b0, m_valid}, 32'd1);
    chk("bp_i_wait", {31'b0, i_wait}, 32'd1);
    chk("bp_d_wait", {31'b0, d_wait}, 32'd1);
    chk("bp_n_acc", n_acc, 32'd0);
    rdy_pct = 100;
    run_to_adv(300);
    tick();

    // randomized pipeline traffic
    rdy_pct = 60; max_dly = 3;
    for (int k = 0; k < 60; k++) begin
      do_step($urandom_range(7, 0) != 0, $urandom & 32'hFFFF_FFFC, 2'($urandom_range(3, 0)),
              $urandom, $urandom, 4'($urandom));
    end

`ifdef ARB_PERF_CNT_EN
    chk("cnt_i_acc", cnt_i_acc, n_i_resp);
    chk("cnt_d_acc", cnt_d_acc, n_d_resp);
    chk("cnt_stall", cnt_stall, stall_ref);
`endif

    // reset while waiting for a response, then a stray response arrives
    rdy_pct = 100; max_dly = 0; hold_resp = 1;
    start_step(1'b1, 32'h200, 2'b00, '0, '0, '0);
    n = 0;
    while (br_st != 1 && n < 20) begin
      tick();
      n++;
    end
    chk("rr_accepted", br_st, 32'd1);
    tick();
    rst = 1'b1; i_req = 0; d_read = 0; d_write = 0;
    @(negedge clk);
    rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("rr_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rr_i_rdata", i_rdata, 32'd0);
    chk("rr_d_rdata", d_rdata, 32'd0);
    chk("rr_m_addr", m_addr, 32'd0);
    i_req = 1'b1; d_read = 1'b1;
    #1;
    chk("rr_i_wait", {31'b0, i_wait}, 32'd1);
    chk("rr_d_wait", {31'b0, d_wait}, 32'd1);
    do_reset();

    // a few steps after reset to show normal operation resumes
    for (int k = 0; k < 4; k++) begin
      do_step(1'b1, 32'h600 + 32'(k * 4), (k % 2 == 0) ? 2'b01 : 2'b00, 32'h700 + 32'(k * 4),
              '0, '0);
    end
`ifdef ARB_PERF_CNT_EN
    chk("cnt_i_acc_4", cnt_i_acc, 32'd4);
    chk("cnt_d_acc_2", cnt_d_acc, 32'd2);
    chk("cnt_stall_2", cnt_stall, stall_ref);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
